// File: rtl/detector_de_monedas.sv
// rtl/detector_de_monedas.sv - coin pulse-width classifier feeding hm/tm/rej to maquina_de_cafe
// Optional accepted-coin counters n5/n10 are built only when COIN_COUNT_EN is defined.
module detector_de_monedas #(
  parameter int MIN5    = 8,
  parameter int MAX5    = 15,
  parameter int MIN10   = 20,
  parameter int MAX10   = 31,
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_in,
  output logic       hm,
  output logic       tm,
  output logic       rej,
  output logic       busy
`ifdef COIN_COUNT_EN
  ,
  output logic [7:0] n5,
  output logic [7:0] n10
`endif
);

  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] L_MIN5  = CNT_W'(MIN5);
  localparam logic [CNT_W-1:0] L_MAX5  = CNT_W'(MAX5);
  localparam logic [CNT_W-1:0] L_MIN10 = CNT_W'(MIN10);
  localparam logic [CNT_W-1:0] L_MAX10 = CNT_W'(MAX10);
  localparam logic [HW-1:0]    HOLD_LD = HW'(HOLDOFF);

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_MEASURE,
    ST_JAM,
    ST_HOLDOFF
  } state_t;

  state_t           state, state_nx;
  logic             s1, s2;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [HW-1:0]    hcnt, hcnt_nx;
  logic             hm_nx, rej_nx, tm_nx;
  logic             fresh, first_smp;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      state     <= ST_ARM;
      cnt       <= '0;
      hcnt      <= '0;
      hm        <= 1'b0;
      rej       <= 1'b0;
      tm        <= 1'b0;
      fresh     <= 1'b1;
      first_smp <= 1'b0;
    end else begin
      s1        <= coin_in;
      s2        <= s1;
      state     <= state_nx;
      cnt       <= cnt_nx;
      hcnt      <= hcnt_nx;
      hm        <= hm_nx;
      rej       <= rej_nx;
      tm        <= tm_nx;
      fresh     <= 1'b0;
      first_smp <= fresh;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hcnt_nx  = hcnt;
    hm_nx    = 1'b0;
    rej_nx   = 1'b0;
    tm_nx    = tm;
    case (state)
      ST_ARM: begin
        if (!s2) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        // s2 still holds its reset value right after release; the first real
        // sample shows up in s1, so a beam blocked through reset goes back to ARM.
        if (first_smp && s1) begin
          state_nx = ST_ARM;
        end else if (s2) begin
          state_nx = ST_MEASURE;
          cnt_nx   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_MEASURE: begin
        if (s2) begin
          if (cnt == CNT_MAX - 1'b1) begin
            cnt_nx   = CNT_MAX;
            rej_nx   = 1'b1;
            state_nx = ST_JAM;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          state_nx = ST_HOLDOFF;
          hcnt_nx  = HOLD_LD;
          if (cnt >= L_MIN5 && cnt <= L_MAX5) begin
            hm_nx = 1'b1;
            tm_nx = 1'b0;
          end else if (cnt >= L_MIN10 && cnt <= L_MAX10) begin
            hm_nx = 1'b1;
            tm_nx = 1'b1;
          end else begin
            rej_nx = 1'b1;
          end
        end
      end
      ST_JAM: begin
        if (!s2) begin
          state_nx = ST_HOLDOFF;
          hcnt_nx  = HOLD_LD;
        end
      end
      ST_HOLDOFF: begin
        if (hcnt == '0) state_nx = ST_ARM;
        else            hcnt_nx  = hcnt - 1'b1;
      end
      default: begin
        state_nx = ST_ARM;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

`ifdef COIN_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      n5  <= 8'd0;
      n10 <= 8'd0;
    end else if (hm_nx) begin
      if (!tm_nx && n5 != 8'hff)  n5  <= n5 + 8'd1;
      if (tm_nx  && n10 != 8'hff) n10 <= n10 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_detector_de_monedas.sv
// tb/tb_detector_de_monedas.sv - directed self-checking bench for detector_de_monedas
module tb_detector_de_monedas;

  logic clk = 1'b0;
  logic rst;
  logic coin_in;
  logic hm, tm, rej, busy;
`ifdef COIN_COUNT_EN
  logic [7:0] n5, n10;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int hm_seen = 0;
  int rej_seen = 0;
  int both_seen = 0;

  always #5 clk = ~clk;

  detector_de_monedas dut (
    .clk     (clk),
    .rst     (rst),
    .coin_in (coin_in),
    .hm      (hm),
    .tm      (tm),
    .rej     (rej),
    .busy    (busy)
`ifdef COIN_COUNT_EN
    ,
    .n5      (n5),
    .n10     (n10)
`endif
  );

  always @(negedge clk) begin
    if (hm)        hm_seen++;
    if (rej)       rej_seen++;
    if (hm && rej) both_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int w);
    coin_in = 1'b1;
    tick(w);
    coin_in = 1'b0;
  endtask

  initial begin
    int h0, r0;
    logic ok;

    coin_in = 1'b0;
    rst     = 1'b1;
    tick(3);
    check("rst_hm", hm, 0);
    check("rst_tm", tm, 0);
    check("rst_rej", rej, 0);
    check("rst_busy", busy, 1);
    rst = 1'b0;
    check("arm_busy", busy, 1);
    tick(1);
    check("idle_busy", busy, 0);
`ifdef COIN_COUNT_EN
    check("rst_n5", n5, 0);
    check("rst_n10", n10, 0);
`endif

    // 12-cycle coin: hm after the 3rd edge past the fall, idle again HOLDOFF+2 later
    h0 = hm_seen;
    pulse(12);
    tick(2);
    check("c12_hm_early", hm, 0);
    tick(1);
    check("c12_hm", hm, 1);
    check("c12_tm", tm, 0);
    check("c12_rej", rej, 0);
    tick(1);
    check("c12_hm_one", hm, 0);
    check("c12_busy_hold", busy, 1);
    tick(16);
    check("c12_busy_arm", busy, 1);
    tick(1);
    check("c12_busy_idle", busy, 0);
    check("c12_hm_count", hm_seen - h0, 1);
`ifdef COIN_COUNT_EN
    check("c12_n5", n5, 1);
`endif
    tick(5);

    // 25-cycle coin: 10-coin, tm held afterwards
    h0 = hm_seen;
    pulse(25);
    tick(3);
    check("c25_hm", hm, 1);
    check("c25_tm", tm, 1);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (tm !== 1'b1) ok = 1'b0;
    end
    check("c25_tm_held", ok, 1);
    check("c25_hm_count", hm_seen - h0, 1);
`ifdef COIN_COUNT_EN
    check("c25_n10", n10, 1);
    check("c25_n5", n5, 1);
`endif

    // out-of-window widths: 3 (glitch-like), 17 (gap), 40 (too long)
    h0 = hm_seen;
    r0 = rej_seen;
    pulse(3);
    tick(3);
    check("c3_rej", rej, 1);
    check("c3_hm", hm, 0);
    tick(27);
    pulse(17);
    tick(30);
    pulse(40);
    tick(30);
    check("bad_rej_count", rej_seen - r0, 3);
    check("bad_hm_count", hm_seen - h0, 0);
    check("bad_tm", tm, 1);

    // jammed beam: rej when cnt saturates at 63, exactly once
    r0 = rej_seen;
    coin_in = 1'b1;
    tick(64);
    check("jam_rej_early", rej, 0);
    tick(1);
    check("jam_rej", rej, 1);
    check("jam_busy", busy, 1);
    tick(1);
    check("jam_rej_one", rej, 0);
    tick(34);
    coin_in = 1'b0;
    check("jam_busy_high", busy, 1);
    tick(20);
    check("jam_busy_arm", busy, 1);
    tick(1);
    check("jam_busy_idle", busy, 0);
    check("jam_rej_count", rej_seen - r0, 1);
    tick(5);

    // reset in the middle of a 25-cycle coin
    coin_in = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(2);
    check("mid_rst_tm", tm, 0);
    rst = 1'b0;
    h0 = hm_seen;
    r0 = rej_seen;
    tick(13);
    coin_in = 1'b0;
    tick(25);
    check("mid_hm_count", hm_seen - h0, 0);
    check("mid_rej_count", rej_seen - r0, 0);
    check("mid_busy", busy, 0);
    pulse(12);
    tick(3);
    check("post_hm", hm, 1);
    check("post_tm", tm, 0);
    tick(25);
    check("post_hm_count", hm_seen - h0, 1);
`ifdef COIN_COUNT_EN
    check("post_n5", n5, 1);
    check("post_n10", n10, 0);
`endif

    check("hm_rej_overlap", both_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
